bus_source_mux: RTL
===================

Name: bus_source_mux

Overview:
- Drives the shared CPU bus: resolves the per-source out-enable strobes from the datapath registers and the ALU/memory/port sources onto BusMuxOut.
- Registers load from BusMuxOut, so this block is the driving end of the bus the registers read.
- Registered, with priority resolution, an idle hold, and conflict monitoring for debug and the verification scoreboard.

Parameters:
- DATA_WIDTH, 32, bus width in bits.
- NUM_SRC, 24, number of bus sources: R0-R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, Csignext.
- SEL_W, 5, width of the encoded select; must satisfy 2**SEL_W >= NUM_SRC.
- CNT_W, 8, width of the conflict counter.

Ports:
- clock  in  1  rising-edge clock.
- clear  in  1  asynchronous, active-low reset.
- src_out  in  NUM_SRC  per-source out-enable strobes; bit i = source i.
- src_data  in  NUM_SRC*DATA_WIDTH  flattened source values; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- BusMuxOut  out  DATA_WIDTH  registered bus value.
- bus_valid  out  1  high when BusMuxOut was loaded by a request in the previous cycle.
- bus_sel  out  SEL_W  encoded index of the source currently on the bus.
- conflict  out  1  one-cycle pulse, registered alongside BusMuxOut, when more than one src_out bit was high.
- conflict_seen  out  1  sticky conflict flag.
- conflict_cnt  out  CNT_W  saturating count of conflict cycles.

Behaviour:
- Reset (clear=0, asynchronous): BusMuxOut=0, bus_valid=0, bus_sel=0, conflict=0, conflict_seen=0, conflict_cnt=0. Reset applies immediately, mid-transfer included; the first post-reset request is served normally.
- Latency: one cycle. src_out/src_data sampled at edge N appear on BusMuxOut after edge N.
- Priority: the lowest set index wins. Example: src_out bits 3 and 20 both set -> source 3 drives the bus, bus_sel=3.
- Exactly one bit set: BusMuxOut<=src_data[i]; bus_sel<=i; bus_valid<=1; conflict<=0.
- Two or more bits set: the winning source is loaded as above; conflict<=1; conflict_seen<=1; conflict_cnt increments.
- conflict_cnt saturates at 2**CNT_W-1 and never wraps. conflict_seen is cleared only by reset.
- No bits set (idle): BusMuxOut and bus_sel hold their previous values; bus_valid<=0; conflict<=0.
- Indices at or above NUM_SRC do not exist. The encoder is built over NUM_SRC bits only, with no X propagation.
- State: a two-state FSM, IDLE/DRIVE, tracked by bus_valid.
  - IDLE -> DRIVE on any request.
  - DRIVE -> IDLE on no request.
  - DRIVE -> DRIVE on back-to-back requests; the new source is loaded each cycle with no bubble.

Optional Feature:
- Macro: BUS_PARITY_EN.
- With the macro defined: adds output port bus_parity (1 bit), the registered even parity (XOR reduction) of the value loaded into BusMuxOut.
  - Updated in the same cycle as BusMuxOut and held while idle.
  - Reset value 0.
- Without the macro: the port and its logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package cpu_bus_pkg holds:
  - DATA_WIDTH.
  - NUM_SRC.
  - Source index constants SRC_R0..SRC_R15, SRC_HI, SRC_LO, SRC_ZHIGH, SRC_ZLOW, SRC_PC, SRC_MDR, SRC_INPORT, SRC_CSIGN.
  - The sel typedef of SEL_W bits.
- One sub-module: bus_prio_encoder. It is combinational: NUM_SRC bits in; outputs sel, any, and multi (popcount>1). It is reused by the control unit's register-select decode.

Test Plan:
- Reset: hold clear=0 with src_out bit 5 set -> all outputs 0. Release clear -> the next edge gives BusMuxOut=src_data[5], bus_sel=5, bus_valid=1.
- Single source: src_out=1<<20 (PC), PC data=32'h0000_0104 -> one edge later BusMuxOut=32'h0000_0104, bus_sel=20, conflict=0.
- Back-to-back: R2=32'hDEAD_BEEF then R7=32'h0000_0007 on consecutive cycles -> BusMuxOut changes on consecutive edges, bus_valid stays 1.
- Idle hold: drive R1=32'h1234_5678, then src_out=0 for 3 cycles -> BusMuxOut stays 32'h1234_5678, bus_valid=0.
- Conflict: src_out bits 3 and 18 set -> BusMuxOut=src_data[3], conflict pulses once, conflict_seen=1, conflict_cnt=1. Hold the conflict for 300 cycles -> conflict_cnt=255 and does not wrap.
- Parity (BUS_PARITY_EN defined): load 32'h0000_0007 -> bus_parity=1; load 32'h0000_0003 -> bus_parity=0.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU bus package.
// Holds the bus geometry, the source index map used by the datapath and the
// control unit, the encoded-select type and the bus FSM state type.
// The parity output is present only when BUS_PARITY_EN is defined; that
// macro is consumed in bus_source_mux_if.sv and bus_source_mux.sv.
package cpu_bus_pkg;

  localparam int DATA_WIDTH = 32;  // bus width in bits
  localparam int NUM_SRC    = 24;  // number of bus sources
  localparam int SEL_W      = 5;   // encoded select width, 2**SEL_W >= NUM_SRC
  localparam int CNT_W      = 8;   // conflict counter width

  // Source index map: bit i of src_out / slot i of src_data.
  localparam int SRC_R0  = 0,  SRC_R1  = 1,  SRC_R2  = 2,  SRC_R3  = 3;
  localparam int SRC_R4  = 4,  SRC_R5  = 5,  SRC_R6  = 6,  SRC_R7  = 7;
  localparam int SRC_R8  = 8,  SRC_R9  = 9,  SRC_R10 = 10, SRC_R11 = 11;
  localparam int SRC_R12 = 12, SRC_R13 = 13, SRC_R14 = 14, SRC_R15 = 15;
  localparam int SRC_HI     = 16;
  localparam int SRC_LO     = 17;
  localparam int SRC_ZHIGH  = 18;
  localparam int SRC_ZLOW   = 19;
  localparam int SRC_PC     = 20;
  localparam int SRC_MDR    = 21;
  localparam int SRC_INPORT = 22;
  localparam int SRC_CSIGN  = 23;

  typedef logic [SEL_W-1:0] sel_t;

  // Bus driver state; DRIVE means BusMuxOut was loaded on the last edge.
  typedef enum logic {
    BUS_IDLE  = 1'b0,
    BUS_DRIVE = 1'b1
  } bus_state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

endpackage

// File: rtl/bus_source_mux_if.sv
// Bus source interface.
// Groups the per-source strobes and data with the registered bus outputs.
//   src_out       : per-source out-enable strobes (bit i = source i)
//   src_data      : flattened source values, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   BusMuxOut     : registered bus value
//   bus_valid     : BusMuxOut was loaded by a request on the previous edge
//   bus_sel       : encoded index of the source on the bus
//   conflict      : registered pulse, more than one strobe was high
//   conflict_seen : sticky conflict flag
//   conflict_cnt  : saturating count of conflict cycles
//   bus_parity    : XOR reduction of BusMuxOut (only with BUS_PARITY_EN)
// Handshake: there is no backpressure. A source requests the bus by raising
// its src_out bit for one cycle; the value is on BusMuxOut after the next
// edge and bus_valid qualifies it for exactly that cycle. Nothing is queued.
// Modports: master = the datapath side offering sources, slave = the mux.
interface bus_source_mux_if;
  import cpu_bus_pkg::*;

  logic [NUM_SRC-1:0]            src_out;
  logic [NUM_SRC*DATA_WIDTH-1:0] src_data;
  logic [DATA_WIDTH-1:0]         BusMuxOut;
  logic                          bus_valid;
  sel_t                          bus_sel;
  logic                          conflict;
  logic                          conflict_seen;
  logic [CNT_W-1:0]              conflict_cnt;
`ifdef BUS_PARITY_EN
  logic                          bus_parity;
`endif

  modport master (
    output src_out, src_data,
    input  BusMuxOut, bus_valid, bus_sel, conflict, conflict_seen, conflict_cnt
`ifdef BUS_PARITY_EN
    , input bus_parity
`endif
  );

  modport slave (
    input  src_out, src_data,
    output BusMuxOut, bus_valid, bus_sel, conflict, conflict_seen, conflict_cnt
`ifdef BUS_PARITY_EN
    , output bus_parity
`endif
  );

endinterface

// File: rtl/bus_prio_encoder.sv
// Combinational lowest-index-first priority encoder.
//   req   : request bits, one per source
//   sel   : index of the lowest set bit (0 when no bit is set)
//   any   : at least one bit set
//   multi : more than one bit set
// Also used by the control unit's register-select decode.
module bus_prio_encoder
  import cpu_bus_pkg::*;
#(
  parameter int N   = NUM_SRC,
  parameter int SW  = SEL_W
) (
  input  logic [N-1:0]  req,
  output logic [SW-1:0] sel,
  output logic          any,
  output logic          multi
);

  // Scan from the top down so the lowest set index is the last to assign.
  always_comb begin
    sel = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) sel = SW'(i);
    end
  end

  assign any   = |req;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = (req & (req - N'(1))) != '0;

endmodule

// File: rtl/bus_source_mux.sv
// Shared CPU bus driver.
// Resolves the per-source out-enable strobes onto the registered BusMuxOut,
// lowest source index first, with one cycle of latency. Idle cycles hold
// the bus value and select; conflicts (several strobes at once) are flagged
// as a pulse, a sticky flag and a saturating counter.
// Ports:
//   clock : rising-edge clock
//   clear : asynchronous active-low reset
//   bus   : bus_source_mux_if.slave (strobes/data in, bus/status out)
// Optional: define BUS_PARITY_EN to add bus.bus_parity, the registered XOR
// reduction of the value loaded into BusMuxOut.
module bus_source_mux
  import cpu_bus_pkg::*;
(
  input  logic               clock,
  input  logic               clear,
  bus_source_mux_if.slave    bus
);

  sel_t                  enc_sel;
  logic                  enc_any;
  logic                  enc_multi;
  logic [DATA_WIDTH-1:0] win_data;

  bus_prio_encoder #(.N(NUM_SRC), .SW(SEL_W)) u_enc (
    .req   (bus.src_out),
    .sel   (enc_sel),
    .any   (enc_any),
    .multi (enc_multi)
  );

  // enc_sel never exceeds NUM_SRC-1, so the slice always lands on real data.
  always_comb begin
    win_data = bus.src_data[int'(enc_sel)*DATA_WIDTH +: DATA_WIDTH];
  end

  // ---------------- FSM: IDLE/DRIVE ----------------
  bus_state_t state_q, state_d;
  logic       valid_o;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) state_q <= BUS_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUS_IDLE:  if (enc_any)  state_d = BUS_DRIVE;
      BUS_DRIVE: if (!enc_any) state_d = BUS_IDLE;
      default:   state_d = BUS_IDLE;
    endcase
  end

  always_comb begin
    valid_o = (state_q == BUS_DRIVE);
  end

  // ---------------- datapath ----------------
  logic [DATA_WIDTH-1:0] bus_q;
  sel_t                  sel_q;
  logic                  conf_q;
  logic                  seen_q;
  logic [CNT_W-1:0]      cnt_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      bus_q  <= '0;
      sel_q  <= '0;
      conf_q <= 1'b0;
      seen_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      // multi implies any, so an idle cycle always clears the pulse.
      conf_q <= enc_multi;
      if (enc_any) begin
        bus_q <= win_data;
        sel_q <= enc_sel;
      end
      if (enc_multi) begin
        seen_q <= 1'b1;
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.BusMuxOut     = bus_q;
  assign bus.bus_sel       = sel_q;
  assign bus.bus_valid     = valid_o;
  assign bus.conflict      = conf_q;
  assign bus.conflict_seen = seen_q;
  assign bus.conflict_cnt  = cnt_q;

`ifdef BUS_PARITY_EN
  logic par_q;

  always_ff @(posedge clock or negedge clear) begin
    if (!clear)       par_q <= 1'b0;
    else if (enc_any) par_q <= ^win_data;
  end

  assign bus.bus_parity = par_q;
`endif

endmodule
